conv_requant: RTL
=================

// Module: conv_requant
// PURPOSE
//  Requantisation stage directly upstream of max_pool. Takes the signed wide conv
//  accumulator stream, adds a per-channel bias, arithmetic-shifts and saturates.
//  Applies ReLU and emits the unsigned DWIDTH stream (data_out/valid_out) that feeds
//  max_pool data_in/valid_in. Tracks pixel/channel position; flags last pixel of each channel.
// PARAMETERS
//  DWIDTH      8    output sample width (unsigned), matches max_pool DWIDTH
//  ACC_WIDTH   20   signed accumulator input width
//  BWIDTH      16   signed bias width
//  NUM_CH      4    output channels (bias entries); >=1
//  PIX_PER_CH  16   valid samples per channel before channel advances; >=1
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               async, active-low; 0 = reset
//  en_requant   in   1               1 = requantise; 0 = bypass (data_out = acc_in[DWIDTH-1:0])
//  acc_in       in   ACC_WIDTH       signed accumulator sample
//  valid_in     in   1               acc_in qualifier; no backpressure
//  shift_amt    in   5               right-shift amount, 0..ACC_WIDTH
//  bias_wr_en   in   1               bias write strobe
//  bias_wr_addr in   clog2(NUM_CH)   bias index (addr >= NUM_CH ignored)
//  bias_wr_data in   BWIDTH          signed bias value
//  data_out     out  DWIDTH          requantised sample -> max_pool data_in
//  valid_out    out  1               data_out qualifier -> max_pool valid_in
//  chan_out     out  clog2(NUM_CH)   channel of data_out
//  last_out     out  1               with valid_out: last pixel of current channel
// BEHAVIOUR
//  - Reset (async assert, sync release): data_out=0, valid_out=0, chan_out=0, last_out=0,
//    pixel/channel counters=0, all bias regs=0, pipeline valids cleared. Mid-stream reset
//    discards in-flight samples; no valid_out until new valid_in plus 3 cycles.
//  - 3-stage pipeline; latency exactly 3 cycles valid_in -> valid_out; 1 sample/cycle
//    throughput; bubbles propagate unchanged.
//  - S1: sum = sext(acc_in) + sext(bias[chan]), width ACC_WIDTH+1; tag chan/last.
//  - S2: sh = sum >>> shift_amt (arithmetic); rounding per CONFIGURATION.
//  - S3: sh<0 -> 0 (ReLU); sh>2^DWIDTH-1 -> 2^DWIDTH-1; else sh[DWIDTH-1:0].
//  - en_requant, shift_amt sampled with the sample in S1/S2; change affects later samples only.
//  - Bypass (en_requant=0): same latency, counters still advance; data_out = acc_in low bits.
//  - Counters advance only on valid_in. pix wraps at PIX_PER_CH-1 -> 0 and chan increments;
//    chan wraps NUM_CH-1 -> 0. last tag = (pix==PIX_PER_CH-1).
//  - Bias write same cycle as S1 read of that entry: S1 uses old value; new value from next cycle.
//  - valid_out=0: data_out/chan_out hold last values; last_out forced 0.
// CONFIGURATION
//  REQUANT_ROUND_EN defined: S2 adds 2^(shift_amt-1) before shift (round-half-up);
//  no add when shift_amt=0. Undefined: pure truncation (floor). Latency identical.
// STRUCTURE
//  Shared package cnn_pkg: DWIDTH/ACC_WIDTH/BWIDTH defaults, clog2 function,
//  saturation constants (SAT_MAX = 2^DWIDTH-1).
//  One sub-module: requant_sat (combinational shift/round/ReLU/saturate), reused by later FC stage.
//  Top holds bias register file, counters and pipeline registers.
// TESTING (defaults except noted; shift_amt=4, bias[0]=16)
//  1. acc_in=144 valid 1 cycle -> 3 cycles later valid_out=1, data_out=10, chan_out=0.
//  2. acc_in=152 -> data_out=10 without REQUANT_ROUND_EN, 11 with it.
//  3. acc_in=-500 -> 0; acc_in=8000 -> 255 (saturate).
//  4. NUM_CH=2, PIX_PER_CH=4, 8 consecutive valids -> chan_out 0,0,0,0,1,1,1,1;
//     last_out on 4th and 8th outputs; 9th sample chan_out=0.
//  5. en_requant=0, acc_in=20'h12345 -> data_out=8'h45 at latency 3; bias write to
//     entry 0 same cycle as sample -> old bias used, next sample new bias.
//  6. reset low with 3 samples in flight -> valid_out=0 immediately, no outputs after
//     release until new input; chan_out=0 on first new output.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and helpers for the CNN datapath blocks (conv_requant,
// requant_sat, max_pool and the later fully-connected stage).
//  - default widths for samples, accumulators and biases
//  - shift-amount field width
//  - saturation constant for the default output width
//  - clog2 / idx_width helpers for sizing index ports and counters
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DWIDTH_DEF    = 8;
    localparam int ACC_WIDTH_DEF = 20;
    localparam int BWIDTH_DEF    = 16;
    localparam int SHIFT_W       = 5;

    // Largest unsigned code at the default output width.
    localparam int SAT_MAX = (1 << DWIDTH_DEF) - 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width that never collapses to zero bits (a single entry still
    // gets a 1-bit index that is simply always 0).
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// -----------------------------------------------------------------------------
// requant_sat
// Purely combinational requantisation helpers, split in two independent halves
// so a pipelined user can register between them and a single-cycle user can
// simply connect shifted -> sat_in.
//   shift half : shifted = (sext(sum_in) + round) >>> shift_amt
//   sat half   : sat_out = ReLU + unsigned saturation of sat_in to DWIDTH bits
// Build option: REQUANT_ROUND_EN defined -> round-half-up (adds 2^(shift_amt-1)
// before the shift, nothing when shift_amt is 0); undefined -> plain floor.
// Ports:
//   sum_in    in  SUM_W     signed biased accumulator
//   shift_amt in  SHIFT_W   arithmetic right-shift amount
//   shifted   out SUM_W+1   signed shifted (and optionally rounded) value
//   sat_in    in  SUM_W+1   signed value to clamp
//   sat_out   out DWIDTH    clamped unsigned code
// -----------------------------------------------------------------------------
module requant_sat
    import cnn_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int SUM_W  = ACC_WIDTH_DEF + 1
) (
    input  logic signed [SUM_W-1:0] sum_in,
    input  logic        [SHIFT_W-1:0] shift_amt,
    output logic signed [SUM_W:0]   shifted,
    input  logic signed [SUM_W:0]   sat_in,
    output logic        [DWIDTH-1:0] sat_out
);

    // One extra bit so the rounding add cannot overflow a full-scale sum.
    localparam int RW = SUM_W + 1;

    logic signed [RW-1:0] sum_ext;
    logic signed [RW-1:0] round_add;

    // NOTE: every signal written in always_comb gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        sum_ext   = {sum_in[SUM_W-1], sum_in};
        round_add = '0;
`ifdef REQUANT_ROUND_EN
        if (shift_amt != '0) begin
            round_add = RW'(1) << (shift_amt - SHIFT_W'(1));
        end
`endif
        shifted = (sum_ext + round_add) >>> shift_amt;
    end

    // Negative -> 0, anything above the DWIDTH range -> all ones.
    always_comb begin
        sat_out = sat_in[DWIDTH-1:0];
        if (sat_in[RW-1]) begin
            sat_out = '0;
        end else if (|sat_in[RW-2:DWIDTH]) begin
            sat_out = '1;
        end
    end

endmodule

// File: rtl/conv_requant.sv
// -----------------------------------------------------------------------------
// conv_requant
// Requantisation stage in front of max_pool. Adds a per-channel bias to the
// signed conv accumulator stream, arithmetic-shifts, applies ReLU and saturates
// to an unsigned DWIDTH sample. Tracks pixel/channel position and flags the
// last pixel of each channel. Three pipeline stages, one sample per cycle,
// no backpressure:
//   S1: sum = sext(acc_in) + sext(bias[chan]); capture chan/last/en/shift
//   S2: shift (and optional rounding)
//   S3: ReLU/saturate or bypass, drive outputs
// Build option: REQUANT_ROUND_EN selects round-half-up in S2 (default: floor).
// Ports:
//   clk          in  1          rising-edge clock
//   reset        in  1          asynchronous, active-low
//   en_requant   in  1          1 = requantise, 0 = bypass low acc bits
//   acc_in       in  ACC_WIDTH  signed accumulator sample
//   valid_in     in  1          acc_in qualifier
//   shift_amt    in  5          right-shift amount
//   bias_wr_en   in  1          bias write strobe
//   bias_wr_addr in  CH_W       bias index (out-of-range writes ignored)
//   bias_wr_data in  BWIDTH     signed bias value
//   data_out     out DWIDTH     requantised sample
//   valid_out    out 1          data_out qualifier
//   chan_out     out CH_W       channel of data_out
//   last_out     out 1          last pixel of the channel (only with valid_out)
// -----------------------------------------------------------------------------
module conv_requant
    import cnn_pkg::*;
#(
    parameter int  DWIDTH     = DWIDTH_DEF,
    parameter int  ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int  BWIDTH     = BWIDTH_DEF,
    parameter int  NUM_CH     = 4,
    parameter int  PIX_PER_CH = 16,
    localparam int CH_W       = idx_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_requant,
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic                 valid_in,
    input  logic [SHIFT_W-1:0]   shift_amt,
    input  logic                 bias_wr_en,
    input  logic [CH_W-1:0]      bias_wr_addr,
    input  logic [BWIDTH-1:0]    bias_wr_data,
    output logic [DWIDTH-1:0]    data_out,
    output logic                 valid_out,
    output logic [CH_W-1:0]      chan_out,
    output logic                 last_out
);

    localparam int SUM_W = ACC_WIDTH + 1;
    localparam int PIX_W = idx_width(PIX_PER_CH);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_CH - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    // ---------------------------------------------------------------- bias RF
    logic [BWIDTH-1:0] bias_q [NUM_CH];

    // NOTE: the bias file is small and must read as zero after reset, so it
    // is built from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) bias_q[i] <= '0;
        end else if (bias_wr_en) begin
            // Addresses >= NUM_CH match no entry and are dropped.
            for (int i = 0; i < NUM_CH; i++) begin
                if (bias_wr_addr == CH_W'(i)) bias_q[i] <= bias_wr_data;
            end
        end
    end

    // ------------------------------------------------------ position counters
    logic [PIX_W-1:0] pix_q;
    logic [CH_W-1:0]  chan_q;
    logic             pix_last;

    assign pix_last = (pix_q == PIX_LAST);

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q  <= '0;
            chan_q <= '0;
        end else if (valid_in) begin
            if (pix_last) begin
                pix_q  <= '0;
                chan_q <= (chan_q == CH_LAST) ? '0 : chan_q + CH_W'(1);
            end else begin
                pix_q  <= pix_q + PIX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------- S1
    // The bias read sees the pre-edge register value, so a write landing in
    // the same cycle only affects later samples.
    logic [BWIDTH-1:0]       bias_cur;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] bias_ext;

    assign bias_cur = bias_q[chan_q];
    assign acc_ext  = {{(SUM_W - ACC_WIDTH){acc_in[ACC_WIDTH-1]}}, acc_in};
    assign bias_ext = {{(SUM_W - BWIDTH){bias_cur[BWIDTH-1]}}, bias_cur};

    logic                    s1_valid;
    logic signed [SUM_W-1:0] s1_sum;
    logic [SHIFT_W-1:0]      s1_shift;
    logic                    s1_en;
    logic [DWIDTH-1:0]       s1_raw;
    logic [CH_W-1:0]         s1_chan;
    logic                    s1_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_shift <= '0;
            s1_en    <= 1'b0;
            s1_raw   <= '0;
            s1_chan  <= '0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            s1_sum   <= acc_ext + bias_ext;
            s1_shift <= shift_amt;
            s1_en    <= en_requant;
            s1_raw   <= acc_in[DWIDTH-1:0];
            s1_chan  <= chan_q;
            s1_last  <= pix_last;
        end
    end

    // ------------------------------------------------------------------- S2
    logic signed [SUM_W:0] shifted;
    logic signed [SUM_W:0] s2_shifted;
    logic [DWIDTH-1:0]     sat_code;

    requant_sat #(
        .DWIDTH (DWIDTH),
        .SUM_W  (SUM_W)
    ) u_requant_sat (
        .sum_in    (s1_sum),
        .shift_amt (s1_shift),
        .shifted   (shifted),
        .sat_in    (s2_shifted),
        .sat_out   (sat_code)
    );

    logic              s2_valid;
    logic              s2_en;
    logic [DWIDTH-1:0] s2_raw;
    logic [CH_W-1:0]   s2_chan;
    logic              s2_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid   <= 1'b0;
            s2_shifted <= '0;
            s2_en      <= 1'b0;
            s2_raw     <= '0;
            s2_chan    <= '0;
            s2_last    <= 1'b0;
        end else begin
            s2_valid   <= s1_valid;
            s2_shifted <= shifted;
            s2_en      <= s1_en;
            s2_raw     <= s1_raw;
            s2_chan    <= s1_chan;
            s2_last    <= s1_last;
        end
    end

    // ------------------------------------------------------------------- S3
    // data_out/chan_out only load on a valid sample and hold across bubbles;
    // last_out is qualified so it can never be seen without valid_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= '0;
            chan_out  <= '0;
        end else begin
            valid_out <= s2_valid;
            last_out  <= s2_valid & s2_last;
            if (s2_valid) begin
                data_out <= s2_en ? sat_code : s2_raw;
                chan_out <= s2_chan;
            end
        end
    end

endmodule
